load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the multicycle control unit / ALU address path and the byte-addressed, big-endian data RAM.
- The RAM provides combinational reads and writes on the clock's falling edge when RW=1.
- Adds a request/response handshake, word/halfword/byte loads with sign or zero extension, and alignment checking.
- Implements sub-word stores as read-modify-write, so the RAM only ever sees aligned 32-bit accesses.

Parameters:
- MEM_BYTES, 256, size of the attached RAM in bytes; used only by the optional bounds check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the sub-word value is in the low bits.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_err  output  1  qualifies rsp_valid: misaligned, illegal size, or out of range.
- rsp_rdata  output  32  extended load result; 0 for stores and errors.
- ram_addr  output  32  word-aligned address to the RAM: {req_addr[31:2],2'b00}.
- ram_din  output  32  write word to the RAM.
- ram_rw  output  1  RAM write enable; 1 only in state WR.
- ram_dout  input  32  combinational RAM read word.

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_rw=0, ram_din=0, ram_addr=0.
- Accept: in IDLE, a rising edge with req_valid=1 latches addr, size, we, signed and wdata. req_ready is 0 in every non-IDLE state; req_valid there is ignored.
- Check at accept, evaluated on the latched values:
  - error if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0;
  - an error goes to RESP with rsp_err=1 and no RAM access (ram_rw stays 0).
- States:
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for a word store.
  - IDLE -> RESP for an error.
  - RD: ram_rw=0, ram_addr driven; ram_dout captured into the internal word register at the closing edge. A load goes to RESP; a sub-word store goes to WR.
  - WR: ram_rw=1, ram_din = merged word (word store: wdata). The RAM writes at this cycle's falling edge. Next state RESP.
  - RESP: rsp_valid=1 for exactly one cycle. Next state IDLE.
- Byte lanes (big-endian):
  - byte offset k occupies bits [31-8k : 24-8k];
  - halfword offset 0 = [31:16], offset 2 = [15:0].
- Load extraction: the selected lane is right-justified, then sign- or zero-extended to 32 bits per the latched signed bit.
- Store merge: wdata[7:0] or wdata[15:0] replaces the addressed lane of the captured word; all other lanes are unchanged.
- Latency, counted from the accept edge:
  - load: rsp_valid in cycle +2;
  - word store: +2;
  - sub-word store: +3;
  - error: +1.
- Outputs are registered: rsp_rdata and rsp_err hold their values through RESP and are cleared to 0 on return to IDLE.
- ram_addr holds the latched aligned address from RD through RESP and is 0 in IDLE.
- No response backpressure: rsp_valid is a pulse the consumer must sample.
- Back-to-back: a new request is accepted in the cycle after RESP, i.e. at the first IDLE edge.
- Reset mid-operation:
  - the next rising edge forces IDLE and all outputs to reset values, and any pending response is dropped;
  - if reset arrives during WR, that cycle's falling-edge write still completes, since reset is synchronous.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: an access whose (addr + access bytes - 1) >= MEM_BYTES is an error at accept. It gets rsp_err=1, latency +1, and no RAM access.
- Undefined: no range check; upper address bits are passed to the RAM unchanged.

Test Plan:
- Reset, then RAM word 0x00000010 = 0x8899AABB; load byte signed at addr 0x11 -> rsp_valid at +2, rsp_rdata=0xFFFFFF99, rsp_err=0.
- Same word; load halfword unsigned at 0x12 -> rsp_rdata=0x0000AABB; load word at 0x10 -> 0x8899AABB.
- Store byte wdata=0x000000CC at 0x13 over 0x8899AABB -> ram_rw high only in the WR cycle (+2); RAM word becomes 0x8899AACC; rsp_valid at +3.
- Load word at 0x12 and load halfword at 0x05 -> rsp_err=1 at +1, ram_rw never asserted, rsp_rdata=0.
- Assert reset in the RD cycle of a byte store -> next edge is IDLE, no rsp_valid, ram_rw stays 0, RAM unchanged.
- With LSU_BOUNDS_CHECK_EN and MEM_BYTES=256, load word at 0xFC -> ok; at 0x100 -> rsp_err=1. Without the macro, 0x100 issues a RAM read.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the address path and a big-endian byte-addressed RAM; sub-word stores use read-modify-write.
// Optional compile-time feature: define LSU_BOUNDS_CHECK_EN to flag accesses past MEM_BYTES as errors at accept.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_rw,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  state_t      state, nextState;
  logic [31:0] addrQ, wdataQ, wordQ;
  logic [1:0]  sizeQ;
  logic        weQ, signedQ;
  logic        fmtErr, rangeErr, accErr;
  logic [1:0]  span;
  logic [32:0] lastByte;
  logic [31:0] mergedWord;

  // Big-endian lane selection: byte offset 0 is the most significant byte.
  function automatic logic [31:0] extractLane(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic sgn);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mergeLane(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0] = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Request legality is judged on the values being latched at the accept edge.
  always_comb begin
    fmtErr = (req_size == 2'b11) ||
             (req_size == 2'b01 && req_addr[0]) ||
             (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_size)
      2'b00:   span = 2'd0;
      2'b01:   span = 2'd1;
      default: span = 2'd3;
    endcase
    lastByte = {1'b0, req_addr} + {31'b0, span};
    rangeErr = lastByte >= 33'(MEM_BYTES);
    accErr   = fmtErr | (BOUNDS_EN & rangeErr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addrQ     <= '0;
      wdataQ    <= '0;
      wordQ     <= '0;
      sizeQ     <= '0;
      weQ       <= 1'b0;
      signedQ   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addrQ   <= req_addr;
            wdataQ  <= req_wdata;
            sizeQ   <= req_size;
            weQ     <= req_we;
            signedQ <= req_signed;
            rsp_err <= accErr;
          end
        end
        RD: begin
          wordQ <= ram_dout;
          if (!weQ) rsp_rdata <= extractLane(ram_dout, addrQ[1:0], sizeQ, signedQ);
        end
        RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Next-state and RAM-side outputs are pure functions of the current state and latched request.
  always_comb begin
    nextState  = state;
    mergedWord = mergeLane(wordQ, addrQ[1:0], sizeQ, wdataQ);
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_rw     = 1'b0;
    ram_addr   = {addrQ[31:2], 2'b00};
    ram_din    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        ram_addr  = '0;
        if (req_valid) begin
          if (accErr)                          nextState = RESP;
          else if (req_we && req_size == 2'b10) nextState = WR;
          else                                  nextState = RD;
        end
      end
      RD:   nextState = weQ ? WR : RESP;
      WR: begin
        ram_rw    = 1'b1;
        ram_din   = mergedWord;
        nextState = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array reference memory and a word-wide RAM model.
// Build with LSU_BOUNDS_CHECK_EN defined to exercise the range check.
module tb_load_store_unit;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit boundsEn = 1'b1;
`else
  localparam bit boundsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, ram_addr, ram_din, ram_dout;
  logic        ram_rw;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acceptCyc;
    int          latency;
    int          writes;
    logic [31:0] wAddr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram [64];
  logic [7:0]  refMem [256];
  int          cyc = 0;
  int          nCompared = 0;
  int          nMismatched = 0;
  int          wrCount = 0;
  int          lastWrCyc = 0;
  logic [31:0] lastWrAddr = '0;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_rw(ram_rw), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: combinational read, write on the falling edge.
  assign ram_dout = ram[ram_addr[7:2]];
  always @(negedge clk) if (ram_rw) ram[ram_addr[7:2]] <= ram_din;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference behaviour computed from the byte array with plain arithmetic.
  function automatic exp_t modelAccess(input logic we, input logic [1:0] sz, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int n;
    longint unsigned val;
    n = sizeBytes(sz);
    e.err   = (sz == 2'b11) || (addr % n != 0) ||
              (boundsEn && (longint'(addr) + n - 1 >= 256));
    e.rdata = '0;
    e.wAddr = addr & 32'hFFFF_FFFC;
    e.writes = 0;
    if (e.err) begin
      e.latency = 1;
    end else if (we) begin
      e.latency = (n == 4) ? 2 : 3;
      e.writes  = 1;
      for (int i = 0; i < n; i++)
        refMem[(addr + i) % 256] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
    end else begin
      e.latency = 2;
      val = 0;
      for (int i = 0; i < n; i++) val = (val << 8) | refMem[(addr + i) % 256];
      if (sgn && val >= (64'd1 << (8 * n - 1))) val = val - (64'd1 << (8 * n));
      e.rdata = val[31:0];
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int waitN = 0;
    @(negedge clk);
    while (!req_ready && waitN < 200) begin
      @(negedge clk);
      waitN++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    e = modelAccess(we, sz, sgn, addr, wdata);
    @(posedge clk);
    e.acceptCyc = cyc;
    sb.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every response and audits RAM writes in between.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (ram_rw) begin
        wrCount++;
        lastWrCyc  = cyc;
        lastWrAddr = ram_addr;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          checkOutput("latency", 32'(cyc - e.acceptCyc), 32'(e.latency));
          checkOutput("ram_writes", 32'(wrCount), 32'(e.writes));
          if (e.writes == 1 && wrCount == 1) begin
            checkOutput("write_cycle", 32'(lastWrCyc - e.acceptCyc), 32'(e.latency - 1));
            checkOutput("write_addr", lastWrAddr, e.wAddr);
          end
        end
        wrCount = 0;
      end else if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
        checkOutput("rsp_idle_rdata", rsp_rdata, 32'd0);
        checkOutput("rsp_idle_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] expWord;
    int gap;
    logic [31:0] a;
    logic [1:0]  sz;

    for (int w = 0; w < 64; w++) begin
      ram[w] = $urandom;
      for (int b = 0; b < 4; b++) refMem[4 * w + b] = 8'(ram[w] >> (24 - 8 * b));
    end

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_ram_rw", 32'(ram_rw), 32'd0);
    checkOutput("reset_ram_addr", ram_addr, 32'd0);
    checkOutput("reset_ram_din", ram_din, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000CC);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h10, 32'h12345678);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h05, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0);
    drain();

    $display("[TB] reset during RD of a byte store");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h13; req_wdata = 32'h00000011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_ram_rw", 32'(ram_rw), 32'd0);
    checkOutput("midreset_ram_addr", ram_addr, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    $display("[TB] random accesses");
    for (int t = 0; t < 150; t++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(32'hF0, 32'h10F)) : 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~32'(sizeBytes(sz) - 1);
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
    drain();
    repeat (2) @(negedge clk);

    for (int w = 0; w < 64; w++) begin
      expWord = {refMem[4 * w], refMem[4 * w + 1], refMem[4 * w + 2], refMem[4 * w + 3]};
      checkOutput($sformatf("ram_word_%0d", w), ram[w], expWord);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
